// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the TX arbiter: FSM states, grant codes,
// packet types and the heartbeat word layout.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIFO_RD,
    FIFO_WAIT,
    LOAD,
    WAIT_HIGH,
    WAIT_LOW
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CFG  = 2'd1,
    GNT_HB   = 2'd2,
    GNT_FIFO = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    PKT_DATA  = 2'b00,
    PKT_TEST  = 2'b01,
    PKT_WRITE = 2'b10,
    PKT_READ  = 2'b11
  } pkt_type_e;

  localparam int HB_W        = 63;
  localparam int HB_SEQ_W    = 16;
  localparam int CNT_W       = 8;
  localparam int HB_TYPE_LSB = 0;
  localparam int HB_ID_LSB   = 2;
  localparam int HB_SEQ_LSB  = 10;
  localparam int HB_PCNT_LSB = 26;
  localparam int HB_BAD_LSB  = 38;
  localparam int HB_RSVD_LSB = 50;
  localparam int HB_FLAG_BIT = 62;

  // Heartbeat is a test packet; the reserved field [61:50] stays zero.
  function automatic logic [HB_W-1:0] hb_word(
    input logic [7:0]          id,
    input logic [HB_SEQ_W-1:0] seq,
    input logic [11:0]         pcnt,
    input logic [11:0]         bad
  );
    logic [HB_W-1:0] w;
    w = '0;
    w[HB_TYPE_LSB +: 2]         = PKT_TEST;
    w[HB_ID_LSB +: 8]           = id;
    w[HB_SEQ_LSB +: HB_SEQ_W]   = seq;
    w[HB_PCNT_LSB +: 12]        = pcnt;
    w[HB_BAD_LSB +: 12]         = bad;
    w[HB_RSVD_LSB +: 12]        = 12'h000;
    w[HB_FLAG_BIT]              = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// UART and event-FIFO side signals of the TX arbiter.
interface tx_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-2:0] tx_data;
  logic             ld_tx_data;
  logic             tx_busy;
  logic [WIDTH-2:0] fifo_data;
  logic             fifo_empty;
  logic             read_fifo_n;

  modport master (
    output tx_data, ld_tx_data, read_fifo_n,
    input  tx_busy, fifo_data, fifo_empty
  );

  modport slave (
    input  tx_data, ld_tx_data, read_fifo_n,
    output tx_busy, fifo_data, fifo_empty
  );
endinterface

// File: rtl/tx_arbiter_hb_timer.sv
// Heartbeat period timer: raises a single pending request every HB_PERIOD
// enabled cycles and keeps the 16-bit heartbeat sequence number.
module hb_timer
  import tx_arb_pkg::*;
#(
  parameter int HB_PERIOD = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hb_enable_i,
  input  logic                hb_take_i,
  output logic                hb_pend_o,
  output logic [HB_SEQ_W-1:0] hb_seq_o
);

  localparam int TW = $clog2(HB_PERIOD);

  logic [TW-1:0]       timer_q, timer_d;
  logic                pend_q, pend_d;
  logic [HB_SEQ_W-1:0] hb_seq_q, hb_seq_d;
  logic                wrap;

  always_comb begin
    timer_d = timer_q;
    wrap    = 1'b0;
    if (!hb_enable_i) begin
      timer_d = '0;
    end else if (timer_q == TW'(HB_PERIOD - 1)) begin
      timer_d = '0;
      wrap    = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    // A wrap while already pending collapses into the existing request.
    pend_d   = (pend_q & ~hb_take_i) | wrap;
    hb_seq_d = hb_take_i ? hb_seq_q + 1'b1 : hb_seq_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      pend_q   <= 1'b0;
      hb_seq_q <= '0;
    end else begin
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      hb_seq_q <= hb_seq_d;
    end
  end

  assign hb_pend_o = pend_q;
  assign hb_seq_o  = hb_seq_q;

endmodule

// File: rtl/tx_arbiter.sv
// Shares the TX UART between config replies, heartbeat packets and the
// event FIFO; owns the FIFO read strobe and the UART load handshake.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int FIFO_LATENCY = 2,
  parameter int HB_PERIOD    = 65535,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             config_req,
  input  logic [WIDTH-2:0] config_data,
  input  logic [7:0]       chip_id,
  input  logic [11:0]      packet_count,
  input  logic [11:0]      bad_packets,
  input  logic             hb_enable,
  output logic [1:0]       grant,
  output logic             arb_busy,
  output logic             config_drop,
  tx_arbiter_if.master     bus
);

  localparam int DW = WIDTH - 1;

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  grant_e              prev_grant_q, prev_grant_d;
  grant_e              pick;
  logic [DW-1:0]       tx_data_q, tx_data_d;
  logic [DW-1:0]       cfg_buf_q, cfg_buf_d;
  logic                cfg_pend_q, cfg_pend_d;
  logic                config_drop_q, config_drop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_take, hb_take, hb_pend;
  logic [HB_SEQ_W-1:0] hb_seq;

  hb_timer #(
    .HB_PERIOD (HB_PERIOD)
  ) u_hb (
    .clk         (clk),
    .reset_n     (reset_n),
    .hb_enable_i (hb_enable),
    .hb_take_i   (hb_take),
    .hb_pend_o   (hb_pend),
    .hb_seq_o    (hb_seq)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prev_grant_d  = prev_grant_q;
    tx_data_d     = tx_data_q;
    cfg_buf_d     = cfg_buf_q;
    cfg_pend_d    = cfg_pend_q;
    config_drop_d = 1'b0;
    cnt_d         = cnt_q;
    cfg_take      = 1'b0;
    hb_take       = 1'b0;
    pick          = GNT_NONE;

    // Fairness: after a config or heartbeat load, a waiting FIFO goes next.
    if ((prev_grant_q == GNT_CFG || prev_grant_q == GNT_HB) && !bus.fifo_empty)
      pick = GNT_FIFO;
    else if (cfg_pend_q)
      pick = GNT_CFG;
    else if (hb_pend)
      pick = GNT_HB;
    else if (!bus.fifo_empty)
      pick = GNT_FIFO;

    unique case (state_q)
      IDLE: begin
        if (!bus.tx_busy && pick != GNT_NONE) begin
          grant_d      = pick;
          prev_grant_d = pick;
          case (pick)
            GNT_CFG: begin
              tx_data_d = cfg_buf_q;
              cfg_take  = 1'b1;
              state_d   = LOAD;
            end
            GNT_HB: begin
              tx_data_d = DW'(hb_word(chip_id, hb_seq, packet_count, bad_packets));
              hb_take   = 1'b1;
              state_d   = LOAD;
            end
            default: state_d = FIFO_RD;
          endcase
        end
      end
      FIFO_RD: begin
        cnt_d   = '0;
        state_d = FIFO_WAIT;
      end
      FIFO_WAIT: begin
        if (cnt_q == CNT_W'(FIFO_LATENCY - 1)) begin
          tx_data_d = bus.fifo_data;
          state_d   = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.tx_busy || cnt_q == CNT_W'(BUSY_TIMEOUT - 1))
          state_d = WAIT_LOW;
        else
          cnt_d = cnt_q + 1'b1;
      end
      WAIT_LOW: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request landing on the cycle its predecessor is granted is kept.
    if (config_req) begin
      if (cfg_pend_q && !cfg_take) begin
        config_drop_d = 1'b1;
      end else begin
        cfg_pend_d = 1'b1;
        cfg_buf_d  = config_data;
      end
    end else if (cfg_take) begin
      cfg_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= GNT_NONE;
      prev_grant_q  <= GNT_NONE;
      tx_data_q     <= '0;
      cfg_buf_q     <= '0;
      cfg_pend_q    <= 1'b0;
      config_drop_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      prev_grant_q  <= prev_grant_d;
      tx_data_q     <= tx_data_d;
      cfg_buf_q     <= cfg_buf_d;
      cfg_pend_q    <= cfg_pend_d;
      config_drop_q <= config_drop_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.ld_tx_data  = (state_q == LOAD);
  assign bus.read_fifo_n = (state_q != FIFO_RD);
  assign grant           = grant_q;
  assign arb_busy        = (state_q != IDLE);
  assign config_drop     = config_drop_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter with behavioural FIFO and UART models.
module tb_tx_arbiter;

  localparam int WIDTH        = 64;
  localparam int FIFO_LATENCY = 2;
  localparam int HB_PERIOD    = 16;
  localparam int BUSY_TIMEOUT = 15;

  typedef struct {
    logic [62:0] data;
    logic [1:0]  gnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        config_req;
  logic [62:0] config_data;
  logic [7:0]  chip_id;
  logic [11:0] packet_count;
  logic [11:0] bad_packets;
  logic        hb_enable;
  logic [1:0]  grant;
  logic        arb_busy;
  logic        config_drop;

  tx_arbiter_if #(.WIDTH(WIDTH)) bus ();

  tx_arbiter #(
    .WIDTH        (WIDTH),
    .FIFO_LATENCY (FIFO_LATENCY),
    .HB_PERIOD    (HB_PERIOD),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .config_req   (config_req),
    .config_data  (config_data),
    .chip_id      (chip_id),
    .packet_count (packet_count),
    .bad_packets  (bad_packets),
    .hb_enable    (hb_enable),
    .grant        (grant),
    .arb_busy     (arb_busy),
    .config_drop  (config_drop),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [62:0] fifo_q[$];
  logic [62:0] fifo_word;
  logic [62:0] last_word;
  int          cyc = 0;
  int          last_rd_cyc = 0;
  int          rd_cnt = 0;
  int          rd_low = 0;
  int          ld_cnt = 0;
  int          drop_cnt = 0;
  int          busy_cnt = 0;
  int          busy_len = 0;
  bit          uart_auto = 1'b1;
  bit          busy_force = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] tb_hb(input logic [15:0] seq);
    logic [62:0] w;
    w        = '0;
    w[1:0]   = 2'b01;
    w[9:2]   = chip_id;
    w[25:10] = seq;
    w[37:26] = packet_count;
    w[49:38] = bad_packets;
    w[62]    = 1'b1;
    return w;
  endfunction

  // FIFO, UART and load monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.read_fifo_n === 1'b0) begin
      rd_low++;
      last_rd_cyc = cyc;
      if (fifo_q.size() > 0) fifo_word = fifo_q.pop_front();
      rd_cnt        = FIFO_LATENCY;
      bus.fifo_data = '1;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) bus.fifo_data = fifo_word;
    end
    bus.fifo_empty = (fifo_q.size() == 0);

    if (bus.ld_tx_data === 1'b1) begin
      ld_cnt++;
      last_word = bus.tx_data;
      $display("[%0t] load #%0d grant=%0d data=%h", $time, ld_cnt, grant, bus.tx_data);
      check_val("ld_while_busy", {63'd0, bus.tx_busy}, 64'd0);
      if (exp_q.size() == 0) begin
        check_val("ld_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("ld_data", {1'b0, bus.tx_data}, {1'b0, e.data});
        check_val("ld_grant", {62'd0, grant}, {62'd0, e.gnt});
        if (e.gnt == 2'd3)
          check_val("fifo_latency", 64'(cyc - last_rd_cyc), 64'(FIFO_LATENCY + 1));
      end
      if (uart_auto) busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = uart_auto ? (busy_cnt > 0) : busy_force;
    if (config_drop === 1'b1) drop_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_pulse(input logic [62:0] w);
    config_data = w;
    config_req  = 1'b1;
    tick(1);
    config_req  = 1'b0;
  endtask

  task automatic push_exp(input logic [62:0] w, input logic [1:0] g);
    exp_t e;
    e.data = w;
    e.gnt  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((arb_busy !== 1'b0 || exp_q.size() != 0 || bus.tx_busy !== 1'b0) && n < 500) begin
      tick(1);
      n++;
    end
    check_val(tag, {63'd0, arb_busy}, 64'd0);
    check_val({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    reset_n        = 1'b0;
    config_req     = 1'b0;
    config_data    = '0;
    chip_id        = 8'h2A;
    packet_count   = 12'h005;
    bad_packets    = 12'h001;
    hb_enable      = 1'b0;
    bus.tx_busy    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    tick(3);
    check_val("rst_tx_data", {1'b0, bus.tx_data}, 64'd0);
    check_val("rst_ld", {63'd0, bus.ld_tx_data}, 64'd0);
    check_val("rst_rd_n", {63'd0, bus.read_fifo_n}, 64'd1);
    check_val("rst_grant", {62'd0, grant}, 64'd0);
    check_val("rst_arb_busy", {63'd0, arb_busy}, 64'd0);
    check_val("rst_drop", {63'd0, config_drop}, 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Config reply while idle: load two cycles after the request.
    busy_len = 10;
    base     = ld_cnt;
    push_exp(63'h4000_0000_1234_5673, 2'd1);
    cfg_pulse(63'h4000_0000_1234_5673);
    check_val("t1_ld_early", {63'd0, bus.ld_tx_data}, 64'd0);
    tick(1);
    check_val("t1_ld", {63'd0, bus.ld_tx_data}, 64'd1);
    check_val("t1_data", {1'b0, bus.tx_data}, 64'h4000_0000_1234_5673);
    check_val("t1_grant", {62'd0, grant}, 64'd1);
    wait_idle("t1_idle");
    check_val("t1_grant_idle", {62'd0, grant}, 64'd0);
    check_val("t1_ld_count", 64'(ld_cnt - base), 64'd1);

    // FIFO drain of three words.
    busy_len = 20;
    base     = ld_cnt;
    n        = rd_low;
    for (int i = 1; i <= 3; i++) begin
      fifo_q.push_back(63'(i));
      push_exp(63'(i), 2'd3);
    end
    wait_idle("t2_idle");
    check_val("t2_rd_pulses", 64'(rd_low - n), 64'd3);
    check_val("t2_ld_count", 64'(ld_cnt - base), 64'd3);

    // All three requesters pending behind a busy UART.
    uart_auto  = 1'b0;
    busy_force = 1'b1;
    tick(2);
    hb_enable = 1'b1;
    fifo_q.push_back(63'h55);
    cfg_pulse(63'h0123_4567_89AB_CDEF);
    tick(19);
    hb_enable = 1'b0;
    push_exp(63'h0123_4567_89AB_CDEF, 2'd1);
    push_exp(63'h55, 2'd3);
    push_exp(tb_hb(16'h0000), 2'd2);
    busy_len  = 5;
    uart_auto = 1'b1;
    wait_idle("t3_idle");
    check_val("t4_hb_id", 64'(last_word[9:2]), 64'h2A);
    check_val("t4_hb_seq", 64'(last_word[25:10]), 64'h0000);
    check_val("t4_hb_pcnt", 64'(last_word[37:26]), 64'h005);
    check_val("t4_hb_bad", 64'(last_word[49:38]), 64'h001);
    check_val("t4_hb_flag", 64'(last_word[62]), 64'd1);

    // Sequence number wrap from FFFF.
    force dut.u_hb.hb_seq_q = 16'hFFFF;
    tick(2);
    release dut.u_hb.hb_seq_q;
    push_exp(tb_hb(16'hFFFF), 2'd2);
    push_exp(tb_hb(16'h0000), 2'd2);
    base      = ld_cnt;
    hb_enable = 1'b1;
    n         = 0;
    while (ld_cnt - base < 2 && n < 100) begin
      tick(1);
      n++;
    end
    hb_enable = 1'b0;
    check_val("t4_hb_loads", 64'(ld_cnt - base), 64'd2);
    wait_idle("t4_idle");

    // Second config request while the first is still pending.
    uart_auto  = 1'b0;
    busy_force = 1'b1;
    tick(2);
    base = drop_cnt;
    cfg_pulse(63'h0AAA_AAAA_0000_0001);
    cfg_pulse(63'h0BBB_BBBB_0000_0002);
    tick(3);
    check_val("t5_drop_count", 64'(drop_cnt - base), 64'd1);
    push_exp(63'h0AAA_AAAA_0000_0001, 2'd1);
    busy_len  = 5;
    uart_auto = 1'b1;
    wait_idle("t5_idle");

    // UART never raises tx_busy: LOAD, 15 WAIT_HIGH cycles, WAIT_LOW, IDLE.
    busy_len = 0;
    push_exp(63'h0CCC_0000_0000_0003, 2'd1);
    cfg_pulse(63'h0CCC_0000_0000_0003);
    n = 0;
    while (bus.ld_tx_data !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check_val("t5_ld_seen", {63'd0, bus.ld_tx_data}, 64'd1);
    n = 0;
    while (arb_busy !== 1'b0 && n < 40) begin
      tick(1);
      n++;
    end
    check_val("t5_timeout_cycles", 64'(n), 64'(BUSY_TIMEOUT + 2));

    // Reset asserted during FIFO_WAIT.
    busy_len = 5;
    fifo_q.push_back(63'h0ABC);
    n = 0;
    while (bus.read_fifo_n !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    check_val("t6_rd_seen", {63'd0, bus.read_fifo_n}, 64'd0);
    tick(1);
    base    = ld_cnt;
    n       = rd_low;
    reset_n = 1'b0;
    #1;
    check_val("t6_tx_data", {1'b0, bus.tx_data}, 64'd0);
    check_val("t6_ld", {63'd0, bus.ld_tx_data}, 64'd0);
    check_val("t6_rd_n", {63'd0, bus.read_fifo_n}, 64'd1);
    check_val("t6_grant", {62'd0, grant}, 64'd0);
    check_val("t6_arb_busy", {63'd0, arb_busy}, 64'd0);
    check_val("t6_drop", {63'd0, config_drop}, 64'd0);
    tick(3);
    reset_n = 1'b1;
    tick(15);
    check_val("t6_no_load", 64'(ld_cnt - base), 64'd0);
    check_val("t6_no_read", 64'(rd_low - n), 64'd0);
    check_val("t6_idle", {63'd0, arb_busy}, 64'd0);
    check_val("end_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
